// File: rtl/wr_burst_packer.sv
// Packs narrow input elements into SPI_WIDTH words and replays them downstream
// as fixed BURST_LEN write bursts, zero-padding bursts closed early by flush.
module wr_burst_packer #(
    parameter int SPI_WIDTH = 32,
    parameter int IN_WIDTH  = 8,
    parameter int BURST_LEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 flush,
    input  logic [3:0]           cmd,
    input  logic                 config_ready,
    output logic                 config_paulse,
    output logic [3:0]           config_data,
    input  logic                 wr_ready,
    output logic                 wr_req,
    output logic [SPI_WIDTH-1:0] wr_data,
    output logic                 busy
);

    localparam int N  = SPI_WIDTH / IN_WIDTH;
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam int AW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        PAD,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SPI_WIDTH-1:0] r_mem [BURST_LEN];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [SPI_WIDTH-1:0] w_push_data;
    logic [SPI_WIDTH-1:0] w_head;

    logic [SPI_WIDTH-1:0] r_pack;
    logic [SPI_WIDTH-1:0] w_merged;
    logic [SW-1:0]        r_slot;
    logic                 r_fpad;
    logic                 r_pending;
    logic [CW-1:0]        r_sent;
    logic [CW-1:0]        r_burst_words;
    logic [3:0]           r_cfg;
    logic                 w_accept;
    logic                 w_last_slot;
    logic                 w_has_data;
    logic                 w_xfer;

    assign w_full      = (r_count == CW'(BURST_LEN));
    assign w_empty     = (r_count == '0);
    assign w_last_slot = (r_slot == SW'(N - 1));
    assign in_ready    = ~(w_last_slot && w_full) && ~r_fpad;
    assign w_accept    = in_valid && in_ready;
    assign w_has_data  = w_accept || (r_slot != '0);
    assign w_head      = r_mem[r_rptr];
    assign w_xfer      = wr_req && wr_ready;
    assign w_pop       = w_xfer && (r_state == SEND);
    assign config_data = r_cfg;
    assign busy        = (r_state != IDLE);

    // First element of a word lands in the MSB slot
    always_comb begin
        w_merged = r_pack;
        for (int k = 0; k < N; k++) begin
            if (w_accept && (r_slot == SW'(k))) begin
                w_merged[(N-1-k)*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_data = w_merged;
        if (r_fpad) begin
            w_push      = ~w_full;
            w_push_data = r_pack;
        end else if (w_accept && w_last_slot) begin
            w_push = 1'b1;
        end else if (flush && w_has_data) begin
            w_push = ~w_full;
        end
    end

    // A flushed partial word that finds the buffer full parks here (r_fpad)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pack <= '0;
            r_slot <= '0;
            r_fpad <= 1'b0;
        end else if (r_fpad) begin
            if (~w_full) begin
                r_fpad <= 1'b0;
                r_pack <= '0;
            end
        end else if (w_accept && w_last_slot) begin
            r_pack <= '0;
            r_slot <= '0;
        end else if (flush && w_has_data) begin
            r_slot <= '0;
            if (w_full) begin
                r_pack <= w_merged;
                r_fpad <= 1'b1;
            end else begin
                r_pack <= '0;
            end
        end else if (w_accept) begin
            r_pack <= w_merged;
            r_slot <= r_slot + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == AW'(BURST_LEN - 1)) ? '0 : r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == AW'(BURST_LEN - 1)) ? '0 : r_rptr + AW'(1);
            end
            if (w_push && ~w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && ~w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (flush && ((r_state != IDLE) || w_has_data ||
                               ~w_empty || r_fpad)) begin
            r_pending <= 1'b1;
        end else if (r_state == START) begin
            r_pending <= 1'b0;
        end else if ((r_state == IDLE) && w_empty &&
                     (r_slot == '0) && ~r_fpad) begin
            r_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_sent        <= '0;
            r_burst_words <= '0;
            r_cfg         <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == START) begin
                r_sent        <= '0;
                r_burst_words <= r_count;
                r_cfg         <= cmd;
            end else if (w_xfer) begin
                r_sent <= r_sent + CW'(1);
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        config_paulse = 1'b0;
        wr_req        = 1'b0;
        wr_data       = '0;
        unique case (r_state)
            IDLE: begin
                if (config_ready && (w_full || (r_pending && ~w_empty))) begin
                    w_next = START;
                end
            end
            START: begin
                config_paulse = 1'b1;
                w_next        = SEND;
            end
            SEND: begin
                if (r_sent == r_burst_words) begin
                    w_next = (r_burst_words == CW'(BURST_LEN)) ? DONE : PAD;
                end else if (~w_empty) begin
                    wr_req  = 1'b1;
                    wr_data = w_head;
                end
            end
            PAD: begin
                if (r_sent == CW'(BURST_LEN)) begin
                    w_next = DONE;
                end else begin
                    wr_req = 1'b1;
                end
            end
            DONE: begin
                if (config_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wr_burst_packer.sv
// Scoreboard bench for wr_burst_packer: a byte-level packing model
// feeds an expected-word queue that is drained on every downstream write.
module tb_wr_burst_packer;

    localparam int BL = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        flush = 1'b0;
    logic [3:0]  cmd = '0;
    logic        config_ready = 1'b1;
    logic        wr_ready = 1'b1;
    logic        in_ready;
    logic        config_paulse;
    logic [3:0]  config_data;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        busy;

    wr_burst_packer #(
        .SPI_WIDTH(32),
        .IN_WIDTH (8),
        .BURST_LEN(BL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .flush        (flush),
        .cmd          (cmd),
        .config_ready (config_ready),
        .config_paulse(config_paulse),
        .config_data  (config_data),
        .wr_ready     (wr_ready),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [31:0] q[$];
    logic [31:0] m_word = '0;
    int          m_nb = 0;
    int          m_words = 0;
    int          n_xfer = 0;
    int          n_pulse = 0;
    int          n_acc = 0;
    bit          mon_on = 1'b1;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    bit          pulse_d = 1'b0;
    logic [3:0]  exp_cmd = '0;
    bit          rnd_en = 1'b0;
    bit          s_done = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (prev_stall) begin
                chk("stall_req", {31'b0, wr_req}, 32'd1);
                chk("stall_data", wr_data, prev_data);
            end
            prev_stall = wr_req && !wr_ready;
            prev_data  = wr_data;
            if (pulse_d) chk("cfg_data", {28'b0, config_data}, {28'b0, exp_cmd});
            pulse_d = config_paulse;
            if (config_paulse) n_pulse++;
            if (wr_req && wr_ready) begin
                n_xfer++;
                if (q.size() == 0) chk("xfer_extra", 32'(q.size()), 32'd1);
                else chk("word", wr_data, q.pop_front());
            end
            if (in_valid && in_ready) begin
                n_acc++;
                m_word = m_word | ({24'b0, in_data} << (8 * (3 - m_nb)));
                m_nb++;
                if (m_nb == 4) begin
                    q.push_back(m_word);
                    m_words++;
                    m_word = '0;
                    m_nb = 0;
                end
            end
            if (flush) begin
                if (m_nb != 0) begin
                    q.push_back(m_word);
                    m_words++;
                    m_word = '0;
                    m_nb = 0;
                end
                while (m_words % BL != 0) begin
                    q.push_back(32'd0);
                    m_words++;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_en) wr_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic put_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic stream(input int first, input int n);
        for (int i = 0; i < n; i++) put_byte(8'(first + i));
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || q.size() != 0) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("idle_timeout", {31'b0, (busy || q.size() != 0)}, 32'd0);
    endtask

    task automatic clear_stats();
        n_xfer  = 0;
        n_pulse = 0;
        n_acc   = 0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_wr_req"}, {31'b0, wr_req}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_pulse"}, {31'b0, config_paulse}, 32'd0);
        chk({tag, "_cfg"}, {28'b0, config_data}, 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_outs("rst");

        // full 256-byte burst
        cmd = 4'h3;
        exp_cmd = 4'h3;
        clear_stats();
        stream(0, 256);
        wait_idle();
        chk("full_pulses", 32'(n_pulse), 32'd1);
        chk("full_xfers", 32'(n_xfer), 32'd64);

        // partial burst closed by flush, zero padded
        cmd = 4'hA;
        exp_cmd = 4'hA;
        clear_stats();
        stream(0, 10);
        pulse_flush();
        wait_idle();
        chk("flush_pulses", 32'(n_pulse), 32'd1);
        chk("flush_xfers", 32'(n_xfer), 32'd64);

        // flush with nothing buffered is ignored
        clear_stats();
        pulse_flush();
        repeat (20) @(posedge clk);
        #1;
        chk("empty_flush_pulses", 32'(n_pulse), 32'd0);
        chk("empty_flush_busy", {31'b0, busy}, 32'd0);

        // random downstream back-pressure
        cmd = 4'h5;
        exp_cmd = 4'h5;
        clear_stats();
        rnd_en = 1'b1;
        stream(0, 256);
        wait_idle();
        rnd_en = 1'b0;
        wr_ready = 1'b1;
        chk("rnd_pulses", 32'(n_pulse), 32'd1);
        chk("rnd_xfers", 32'(n_xfer), 32'd64);

        // downstream blocked: input stalls once buffer and pack fill
        cmd = 4'h6;
        exp_cmd = 4'h6;
        clear_stats();
        wr_ready = 1'b0;
        s_done = 1'b0;
        fork
            begin
                stream(0, 512);
                s_done = 1'b1;
            end
        join_none
        repeat (300) @(posedge clk);
        #1;
        chk("block_accepted", 32'(n_acc), 32'(BL * 4 + 3));
        chk("block_in_ready", {31'b0, in_ready}, 32'd0);
        wr_ready = 1'b1;
        t = 0;
        while (!s_done && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("block_stream_done", {31'b0, s_done}, 32'd1);
        wait_idle();
        chk("block_pulses", 32'(n_pulse), 32'd2);
        chk("block_xfers", 32'(n_xfer), 32'd128);
        chk("block_accepted_all", 32'(n_acc), 32'd512);

        // reset in the middle of a burst
        cmd = 4'h7;
        exp_cmd = 4'h7;
        clear_stats();
        stream(0, 256);
        t = 0;
        while (n_xfer < 20 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("mid_reach20", 32'(n_xfer), 32'd20);
        reset = 1'b1;
        mon_on = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outs("mid_rst");
        reset = 1'b0;
        q.delete();
        m_word = '0;
        m_nb = 0;
        m_words = 0;
        prev_stall = 1'b0;
        pulse_d = 1'b0;
        mon_on = 1'b1;
        clear_stats();
        stream(0, 256);
        wait_idle();
        chk("post_rst_pulses", 32'(n_pulse), 32'd1);
        chk("post_rst_xfers", 32'(n_xfer), 32'd64);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
